codec_capture: RTL

CODEC_CAPTURE -- requirements
Module: codec_capture

---
 rtl/codec_pkg.sv | 13 +
 rtl/capture_fifo.sv | 62 ++++++
 rtl/codec_capture.sv | 81 ++++++++
 3 files changed

// File: rtl/codec_pkg.sv
// Shared defaults and the stereo-pair layout for the codec capture path.
package codec_pkg;

    localparam int CODEC_SAMPLE_W = 16;
    localparam int CODEC_DEPTH    = 16;

    // Left channel occupies the upper half of a stored FIFO word.
    typedef struct packed {
        logic [CODEC_SAMPLE_W-1:0] l;
        logic [CODEC_SAMPLE_W-1:0] r;
    } stereo_pair_t;

endpackage

// File: rtl/capture_fifo.sv
// Generic first-word-fall-through FIFO: storage, wrapping pointers and occupancy.
// Latency: a write is visible at the head one cycle later; a pop retires the head on the same edge.
// Backpressure: a write while full is dropped unless a pop happens in the same cycle.
module capture_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_dat_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_dat_o,
    output logic                   rd_vld_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push, pop;

    assign rd_vld_o = (level_q != '0);
    assign full_o   = (level_q == (AW+1)'(DEPTH));
    assign level_o  = level_q;
    assign rd_dat_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
    assign pop  = rd_en_i && rd_vld_o;
    assign push = wr_en_i && (!full_o || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + (AW+1)'(1);
        else if (pop && !push) level_d = level_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/codec_capture.sv
// Captures one stereo pair per codec frame edge into a FIFO; sticky overflow; optional mono mix (CODEC_CAPTURE_MIX_EN).
// Latency: pair appears at the head one cycle after the frame edge; mix is combinational from the head.
// Backpressure: none toward the codec -- frames arriving while full (no pop) are dropped and flagged.
module codec_capture
    import codec_pkg::*;
#(
    parameter int DEPTH    = CODEC_DEPTH,
    parameter int SAMPLE_W = CODEC_SAMPLE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_frame,
    input  logic [SAMPLE_W-1:0]    adc_sample_l,
    input  logic [SAMPLE_W-1:0]    adc_sample_r,
    input  logic                   capture_en,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [SAMPLE_W-1:0]    rd_sample_l,
    output logic [SAMPLE_W-1:0]    rd_sample_r,
    output logic [SAMPLE_W-1:0]    rd_sample,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   clear_overflow,
    output logic                   overflow
);

    logic                  new_frame_q;
    logic                  overflow_q, overflow_d;
    logic                  frame_edge, wr_req, full;
    logic [2*SAMPLE_W-1:0] head;

    assign frame_edge = new_frame && !new_frame_q;
    assign wr_req     = frame_edge && capture_en;

    capture_fifo #(
        .DEPTH (DEPTH),
        .W     (2*SAMPLE_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .wr_en_i  (wr_req),
        .wr_dat_i ({adc_sample_l, adc_sample_r}),
        .rd_en_i  (rd_en),
        .rd_dat_o (head),
        .rd_vld_o (rd_valid),
        .full_o   (full),
        .level_o  (level)
    );

    // A fresh drop wins over a same-cycle clear so no overflow event is lost.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_req && full && !(rd_en && rd_valid)) overflow_d = 1'b1;
        else if (clear_overflow)                    overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            new_frame_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            new_frame_q <= new_frame;
            overflow_q  <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    // Head is forced to zero when empty so stale storage never leaks out.
    assign rd_sample_l = rd_valid ? head[2*SAMPLE_W-1:SAMPLE_W] : '0;
    assign rd_sample_r = rd_valid ? head[SAMPLE_W-1:0]          : '0;

`ifdef CODEC_CAPTURE_MIX_EN
    logic signed [SAMPLE_W:0] mix_sum;
    assign mix_sum   = $signed({rd_sample_l[SAMPLE_W-1], rd_sample_l})
                     + $signed({rd_sample_r[SAMPLE_W-1], rd_sample_r});
    assign rd_sample = SAMPLE_W'(mix_sum >>> 1);
`else
    assign rd_sample = rd_sample_l;
`endif

endmodule
